// File: rtl/sram_controller_pkg.sv
// ---------------------------------------------------------------------------
// sram_controller_pkg
//   Shared definitions for the MEM-stage SRAM controller: FSM state
//   encoding, data-memory base address, SRAM bus widths and the byte
//   address to SRAM word index mapping.
// ---------------------------------------------------------------------------
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DATA_MEM_BASE = 1024;
    localparam int SRAM_ADDR_W   = 18;
    localparam int SRAM_DATA_W   = 16;
    // One 32-bit word spans two half-word locations, so the word index is
    // one bit narrower than the SRAM address.
    localparam int SRAM_WORD_W   = SRAM_ADDR_W - 1;

    // Byte address -> 32-bit word index inside data memory. Bits above the
    // SRAM range are silently dropped, so out-of-range addresses alias.
    function automatic logic [SRAM_WORD_W-1:0] word_index(
        input logic [31:0] byte_addr,
        input logic [31:0] base_addr
    );
        return SRAM_WORD_W'((byte_addr - base_addr) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// ---------------------------------------------------------------------------
// sram_controller_if
//   Pipeline-side request/response bundle between the EXE/MEM register and
//   the SRAM controller.
//     wr_en, rd_en  store / load request
//     address       byte address (alu_result)
//     write_data    store value (st_val)
//     read_data     loaded word, registered in the controller
//     ready         0 while an access is pending; freeze = ~ready
//   master: pipeline side, slave: controller side.
// ---------------------------------------------------------------------------
interface sram_controller_if;

    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//   Splits a 32-bit load/store into two 16-bit SRAM accesses (low half at
//   even half-word address, high half at odd). ready is held low from the
//   request cycle until the access completes, which freezes the pipeline
//   for 1 + 2*PHASE_CYCLES cycles.
//   Ports:
//     clk, rst      system clock, synchronous active-high reset
//     bus           pipeline request/response (sram_controller_if.slave)
//     SRAM_DQ       16-bit bidirectional SRAM data bus
//     SRAM_ADDR     18-bit half-word address, registered
//     SRAM_WE_N     write enable, active low
//     SRAM_OE_N     output enable, active low
//     SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  tied active (full half-word access)
// ---------------------------------------------------------------------------
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int BASE_ADDR    = DATA_MEM_BASE,
    parameter int PHASE_CYCLES = 2              // must be >= 2
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_controller_if.slave       bus,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    localparam int                CNT_W    = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic                   is_write;
    logic                   request;
    logic                   phase_last;
    logic                   dq_oe;
    logic [SRAM_DATA_W-1:0] dq_out;

    assign request    = bus.wr_en | bus.rd_en;
    assign phase_last = (cnt == CNT_LAST);

    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign SRAM_DQ = dq_oe ? dq_out : 'z;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        bus.ready = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = bus.write_data[15:0];

        unique case (state)
            IDLE: begin
                if (request) begin
                    state_nxt = LOW;
                    bus.ready = 1'b0;
                end
            end
            LOW, HIGH: begin
                bus.ready = 1'b0;
                if (state == HIGH) dq_out = bus.write_data[31:16];
                if (phase_last)    state_nxt = (state == LOW) ? HIGH : DONE;
                if (is_write) begin
                    dq_oe     = 1'b1;
                    // Release WE_N on the last cycle so address and data are
                    // held stable across the rising edge of the strobe.
                    SRAM_WE_N = phase_last;
                end else begin
                    SRAM_OE_N = 1'b0;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // A reset during an access must not leave a strobe or the data bus
        // active in the cycle it is applied.
        if (rst) begin
            SRAM_WE_N = 1'b1;
            SRAM_OE_N = 1'b1;
            dq_oe     = 1'b0;
        end
    end

    // NOTE: all datapath flops, read_data included, are reset explicitly;
    // there is no storage array here that could be left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            is_write      <= 1'b0;
            SRAM_ADDR     <= '0;
            bus.read_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (request) begin
                        // Write wins when both enables are set.
                        is_write  <= bus.wr_en;
                        SRAM_ADDR <= {word_index(bus.address, 32'(BASE_ADDR)), 1'b0};
                    end
                end
                LOW, HIGH: begin
                    cnt <= phase_last ? '0 : CNT_W'(cnt + 1'b1);
                    if (phase_last) begin
                        if (state == LOW) begin
                            SRAM_ADDR[0] <= 1'b1;
                            if (!is_write) bus.read_data[15:0] <= SRAM_DQ;
                        end else if (!is_write) begin
                            bus.read_data[31:16] <= SRAM_DQ;
                        end
                    end
                end
                DONE:    cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_controller
//   Directed bench for sram_controller with a behavioural 256K x 16 SRAM,
//   a word-level reference memory and a queue of expected load results.
// ---------------------------------------------------------------------------
module tb_sram_controller;
    import sram_controller_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_controller_if bus ();

    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    sram_controller #(.BASE_ADDR(1024), .PHASE_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (we_n),
        .SRAM_OE_N (oe_n),
        .SRAM_CE_N (ce_n),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n)
    );

    // Behavioural asynchronous SRAM: drives on read, stores on a WE_N-low edge.
    logic [15:0] sram_mem [0:262143];
    assign sram_dq = (!oe_n && we_n) ? sram_mem[sram_addr] : 16'hzzzz;
    always @(posedge clk) if (!we_n) sram_mem[sram_addr] <= sram_dq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] addr);
        logic [31:0] d;
        d = addr - 32'd1024;
        return int'(d[18:2]);
    endfunction

    // Present one request in an IDLE cycle, follow it to DONE, compare any
    // load result against the scoreboard, then drop the request.
    task automatic access(input string tag, input logic w, input logic r,
                          input logic [31:0] addr, input logic [31:0] data,
                          output int freeze, output int we_low,
                          output int we_falls, output int oe_low);
        logic        prev_we;
        logic [31:0] exp;
        prev_we = 1'b1;
        freeze = 0; we_low = 0; we_falls = 0; oe_low = 0;
        @(negedge clk);
        bus.wr_en = w; bus.rd_en = r; bus.address = addr; bus.write_data = data;
        if (w) ref_mem[word_of(addr)] = data;
        else if (r) exp_q.push_back(ref_mem.exists(word_of(addr)) ? ref_mem[word_of(addr)] : 32'h0);
        #1;
        for (int n = 0; n < 20 && !bus.ready; n++) begin
            freeze++;
            if (!we_n) begin
                we_low++;
                if (prev_we) we_falls++;
            end
            prev_we = we_n;
            if (!oe_n) oe_low++;
            @(negedge clk);
            #1;
        end
        check({tag, "_done"}, {31'b0, bus.ready}, 32'h1);
        if (r && !w) begin
            check({tag, "_sb_nonempty"}, exp_q.size(), 32'd1);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check({tag, "_read_data"}, bus.read_data, exp);
            end
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fz, wl, wf, ol, fz2;

        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0000;
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        bus.address = 32'h0; bus.write_data = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: idle after reset
        repeat (10) @(negedge clk);
        check("idle_ready", {31'b0, bus.ready}, 32'h1);
        check("idle_we_n", {31'b0, we_n}, 32'h1);
        check("idle_oe_n", {31'b0, oe_n}, 32'h1);
        check("idle_dq_oe", {31'b0, dut.dq_oe}, 32'h0);
        check("idle_read_data", bus.read_data, 32'h0);
        check("idle_addr", {14'b0, sram_addr}, 32'h0);
        check("idle_ce_ub_lb", {29'b0, ce_n, ub_n, lb_n}, 32'h0);

        // 2: store 0xDEADBEEF to 1028
        access("st1", 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, fz, wl, wf, ol);
        check("st1_freeze", fz, 32'd5);
        check("st1_we_low_cycles", wl, 32'd2);
        check("st1_we_pulses", wf, 32'd2);
        check("st1_oe_low", ol, 32'd0);
        check("st1_mem2", {16'b0, sram_mem[2]}, 32'h0000BEEF);
        check("st1_mem3", {16'b0, sram_mem[3]}, 32'h0000DEAD);

        // 3: load it back, result must hold afterwards
        access("ld1", 1'b0, 1'b1, 32'd1028, 32'h0, fz, wl, wf, ol);
        check("ld1_freeze", fz, 32'd5);
        check("ld1_we_low", wl, 32'd0);
        repeat (3) @(negedge clk);
        check("ld1_hold", bus.read_data, 32'hDEADBEEF);

        // 4: store then load presented the cycle after DONE
        access("st2", 1'b1, 1'b0, 32'd1032, 32'h12345678, fz, wl, wf, ol);
        access("ld2", 1'b0, 1'b1, 32'd1032, 32'h0, fz2, wl, wf, ol);
        check("b2b_freeze_total", fz + fz2, 32'd10);
        check("b2b_mem4", {16'b0, sram_mem[4]}, 32'h00005678);

        // 5: reset on the 2nd LOW cycle of a store to 1036
        @(negedge clk);
        bus.wr_en = 1'b1; bus.address = 32'd1036; bus.write_data = 32'h0BADF00D;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; bus.wr_en = 1'b0;
        #1;
        check("rst_we_n_during", {31'b0, we_n}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", {31'b0, bus.ready}, 32'h1);
        check("rst_we_n", {31'b0, we_n}, 32'h1);
        check("rst_oe_n", {31'b0, oe_n}, 32'h1);
        check("rst_dq_oe", {31'b0, dut.dq_oe}, 32'h0);
        check("rst_addr", {14'b0, sram_addr}, 32'h0);
        check("rst_read_data", bus.read_data, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_mem7", {16'b0, sram_mem[7]}, 32'h0);

        // Reload a known value so the next step can see read_data unchanged.
        access("ld3", 1'b0, 1'b1, 32'd1032, 32'h0, fz, wl, wf, ol);

        // 6: both enables set -> write only
        access("both", 1'b1, 1'b1, 32'd1040, 32'hA5A55A5A, fz, wl, wf, ol);
        check("both_freeze", fz, 32'd5);
        check("both_oe_low", ol, 32'd0);
        check("both_we_pulses", wf, 32'd2);
        check("both_mem8", {16'b0, sram_mem[8]}, 32'h00005A5A);
        check("both_mem9", {16'b0, sram_mem[9]}, 32'h0000A5A5);
        check("both_read_data", bus.read_data, 32'h12345678);

        // Address 1024 + 4*2^17 aliases to word 0.
        access("alias_st", 1'b1, 1'b0, 32'd1024 + 32'd4 * 32'd131072, 32'hCAFEF00D, fz, wl, wf, ol);
        check("alias_mem0", {16'b0, sram_mem[0]}, 32'h0000F00D);
        check("alias_mem1", {16'b0, sram_mem[1]}, 32'h0000CAFE);
        access("alias_ld", 1'b0, 1'b1, 32'd1024, 32'h0, fz, wl, wf, ol);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
